mem_stall_ctrl: RTL and testbench

Parametrised pipeline freeze controller that tracks outstanding memory requests on `NUM_PORTS` independent memory ports (port 0 = imem, port 1 = dmem by convention). It issues a global `freeze` while any port waits on a live request, and discards responses to requests squashed by a flush. It also reports per-port protocol errors and watchdog timeouts, and keeps a saturating stall-cycle counter. It sits beside the pipeline registers and drives their enable and the PC hold.

---
 rtl/mem_stall_ctrl_pkg.sv | 25 ++
 rtl/mem_stall_ctrl_port_tracker.sv | 120 ++++++++++++
 rtl/mem_stall_ctrl.sv | 57 +++++
 tb/tb_mem_stall_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types for the memory stall controller and the pipeline port map.

package rv32i_types;
    localparam int unsigned IMEM_PORT = 0;
    localparam int unsigned DMEM_PORT = 1;
endpackage

package mem_stall_ctrl_pkg;

    // How a returning response is matched against the outstanding requests.
    typedef enum logic [1:0] {
        RESP_NONE      = 2'd0,
        RESP_STALE     = 2'd1,
        RESP_LIVE      = 2'd2,
        RESP_UNMATCHED = 2'd3
    } resp_class_e;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_port_tracker.sv
// Tracks live and squashed (stale) requests on one memory port, the watchdog
// for that port, and its sticky protocol / timeout error flags.

module mem_port_tracker
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic resp,
    input  logic flush,
    output logic req_ok,
    output logic resp_use,
    output logic port_wait,
    output logic proto_err,
    output logic timeout_err
);

    localparam int unsigned OW = cnt_width(MAX_OUTST);
    localparam int unsigned WW = cnt_width(TIMEOUT);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTST);
    localparam logic [WW-1:0] TO_CNT  = WW'(TIMEOUT);
    localparam logic          WDOG_ON = (TIMEOUT != 0);

    logic [OW-1:0] live;
    logic [OW-1:0] stale;
    logic [OW-1:0] live_nxt;
    logic [OW-1:0] stale_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_inc;
    logic          proto_hit;
    logic          wait_clear;
    resp_class_e   resp_class;

    // Classify this cycle's response against the pre-update counters; stale first.
    always_comb begin
        resp_class = RESP_NONE;
        if (resp) begin
            if (stale != '0) begin
                resp_class = RESP_STALE;
            end else if (live != '0) begin
                resp_class = RESP_LIVE;
            end else begin
                resp_class = RESP_UNMATCHED;
            end
        end
    end

    // Zero-latency status toward the pipeline.
    always_comb begin
        req_ok     = ({1'b0, live} + {1'b0, stale}) < {1'b0, MAX_CNT};
        resp_use   = (resp_class == RESP_LIVE);
        port_wait  = (live != '0) && !(resp_use && (live == OW'(1))) && !flush;
        wait_clear = !port_wait || resp_use;
        wait_inc   = wait_cnt + WW'(1);
    end

    // Next counter values: response retire, then flush, then new request.
    always_comb begin
        live_nxt  = live;
        stale_nxt = stale;
        proto_hit = 1'b0;
        case (resp_class)
            RESP_STALE:     stale_nxt = stale - OW'(1);
            RESP_LIVE:      live_nxt  = live - OW'(1);
            RESP_UNMATCHED: proto_hit = 1'b1;
            default:        ;
        endcase
        if (flush) begin
            stale_nxt = stale_nxt + live_nxt;
            live_nxt  = '0;
        end
        if (req) begin
            if (req_ok) begin
                live_nxt = live_nxt + OW'(1);
            end else begin
                proto_hit = 1'b1;
            end
        end
    end

    // Outstanding-request counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live  <= '0;
            stale <= '0;
        end else begin
            live  <= live_nxt;
            stale <= stale_nxt;
        end
    end

    // Sticky protocol error: unmatched response or request while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (proto_hit) begin
            proto_err <= 1'b1;
        end
    end

    // Watchdog: counts consecutive waiting cycles without a live response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (!WDOG_ON || wait_clear) begin
            wait_cnt <= '0;
        end else if (wait_cnt != TO_CNT) begin
            wait_cnt <= wait_inc;
            if (wait_inc == TO_CNT) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Pipeline freeze controller: one tracker per memory port, global freeze and
// a saturating count of frozen cycles.

module mem_stall_ctrl #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] resp,
    input  logic [NUM_PORTS-1:0] flush,
    output logic [NUM_PORTS-1:0] req_ok,
    output logic [NUM_PORTS-1:0] resp_use,
    output logic [NUM_PORTS-1:0] port_wait,
    output logic                 freeze,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [NUM_PORTS-1:0] proto_err,
    output logic [NUM_PORTS-1:0] timeout_err
);

    // One independent tracker per memory port.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        mem_port_tracker #(
            .MAX_OUTST (MAX_OUTST),
            .TIMEOUT   (TIMEOUT)
        ) u_trk (
            .clk         (clk),
            .rst         (rst),
            .req         (req[i]),
            .resp        (resp[i]),
            .flush       (flush[i]),
            .req_ok      (req_ok[i]),
            .resp_use    (resp_use[i]),
            .port_wait   (port_wait[i]),
            .proto_err   (proto_err[i]),
            .timeout_err (timeout_err[i])
        );
    end

    // Any waiting port freezes the whole pipeline.
    always_comb begin
        freeze = |port_wait;
    end

    // Saturating count of frozen cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (freeze && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: directed scenarios then random traffic, all
// checked against an in-order request queue model.

module tb_mem_stall_ctrl;
    import rv32i_types::*;

    localparam int NP = 2;
    localparam int MO = 2;
    localparam int TO = 8;
    localparam int CW = 8;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] resp = '0;
    logic [NP-1:0] flush = '0;
    logic [NP-1:0] req_ok;
    logic [NP-1:0] resp_use;
    logic [NP-1:0] port_wait;
    logic          freeze;
    logic [CW-1:0] stall_cycles;
    logic [NP-1:0] proto_err;
    logic [NP-1:0] timeout_err;

    int tests = 0;
    int fails = 0;

    // Model: per port, an in-order queue of issued requests (1 = live, 0 = squashed).
    bit mq [NP][$];
    int m_wait [NP];
    bit m_perr [NP];
    bit m_terr [NP];
    int m_stall;

    mem_stall_ctrl #(
        .NUM_PORTS (NP),
        .MAX_OUTST (MO),
        .TIMEOUT   (TO),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .resp         (resp),
        .flush        (flush),
        .req_ok       (req_ok),
        .resp_use     (resp_use),
        .port_wait    (port_wait),
        .freeze       (freeze),
        .stall_cycles (stall_cycles),
        .proto_err    (proto_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            m_wait[p] = 0;
            m_perr[p] = 1'b0;
            m_terr[p] = 1'b0;
        end
        m_stall = 0;
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag, input logic [NP-1:0] rq, input logic [NP-1:0] rs,
                        input logic [NP-1:0] fl);
        logic [NP-1:0] e_ok, e_use, e_wait, e_perr, e_terr;
        int nlive;
        req = rq;
        resp = rs;
        flush = fl;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            nlive = 0;
            for (int k = 0; k < mq[p].size(); k++) if (mq[p][k]) nlive++;
            e_ok[p]   = (mq[p].size() < MO);
            e_use[p]  = rs[p] && (mq[p].size() > 0) && mq[p][0];
            e_wait[p] = ((nlive - (e_use[p] ? 1 : 0)) > 0) && !fl[p];
            e_perr[p] = m_perr[p];
            e_terr[p] = m_terr[p];
        end
        chk({tag, ".req_ok"},      32'(req_ok),       32'(e_ok));
        chk({tag, ".resp_use"},    32'(resp_use),     32'(e_use));
        chk({tag, ".port_wait"},   32'(port_wait),    32'(e_wait));
        chk({tag, ".freeze"},      32'(freeze),       32'(|e_wait));
        chk({tag, ".stall"},       32'(stall_cycles), 32'(m_stall));
        chk({tag, ".proto_err"},   32'(proto_err),    32'(e_perr));
        chk({tag, ".timeout_err"}, 32'(timeout_err),  32'(e_terr));
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (rs[p]) begin
                if (mq[p].size() > 0) mq[p].delete(0);
                else m_perr[p] = 1'b1;
            end
            if (fl[p]) for (int k = 0; k < mq[p].size(); k++) mq[p][k] = 1'b0;
            if (rq[p]) begin
                if (e_ok[p]) mq[p].push_back(1'b1);
                else m_perr[p] = 1'b1;
            end
            if (!e_wait[p] || e_use[p]) begin
                m_wait[p] = 0;
            end else if (m_wait[p] < TO) begin
                m_wait[p]++;
                if (m_wait[p] == TO) m_terr[p] = 1'b1;
            end
        end
        if ((|e_wait) && (m_stall < SMAX)) m_stall++;
        #1;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        req = '0;
        resp = '0;
        flush = '0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk({tag, ".req_ok"},    32'(req_ok),       32'h3);
        chk({tag, ".freeze"},    32'(freeze),       32'h0);
        chk({tag, ".stall"},     32'(stall_cycles), 32'h0);
        chk({tag, ".proto_err"}, 32'(proto_err),    32'h0);
        chk({tag, ".timeout"},   32'(timeout_err),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NP-1:0] rq, rs, fl;
        logic [NP-1:0] imem_bit, dmem_bit;
        imem_bit = NP'(1) << IMEM_PORT;
        dmem_bit = NP'(1) << DMEM_PORT;

        model_clear();
        do_reset("reset");
        for (int i = 0; i < 10; i++) step("idle", '0, '0, '0);

        // dmem request answered four cycles later.
        step("dm_req", dmem_bit, '0, '0);
        for (int i = 0; i < 3; i++) step("dm_wait", '0, '0, '0);
        step("dm_resp", '0, dmem_bit, '0);
        chk("dm_stall_total", 32'(stall_cycles), 32'd3);

        // Two imem requests, flushed, then both responses discarded.
        step("fl_req1", imem_bit, '0, '0);
        step("fl_req2", imem_bit, '0, '0);
        step("fl_flush", '0, '0, imem_bit);
        step("fl_resp1", '0, imem_bit, '0);
        step("fl_resp2", '0, imem_bit, '0);
        step("fl_after", '0, '0, '0);
        chk("fl_req_ok", 32'(req_ok[IMEM_PORT]), 32'd1);

        // Request while full is dropped and flagged.
        step("full_req1", imem_bit, '0, '0);
        step("full_req2", imem_bit, '0, '0);
        step("full_req3", imem_bit, '0, '0);
        chk("full_proto", 32'(proto_err[IMEM_PORT]), 32'd1);
        step("full_resp1", '0, imem_bit, '0);
        step("full_resp2", '0, imem_bit, '0);
        step("full_idle", '0, '0, '0);

        // Mid-operation reset with a dmem request outstanding.
        step("mid_req", dmem_bit, '0, '0);
        do_reset("mid_reset");
        step("post_reset", '0, '0, '0);

        // Same-cycle flush + resp + req with one live request.
        step("same_req", imem_bit, '0, '0);
        step("same_all", imem_bit, imem_bit, imem_bit);
        step("same_next", '0, '0, '0);
        chk("same_wait", 32'(port_wait[IMEM_PORT]), 32'd1);
        step("same_resp", '0, imem_bit, '0);

        // Unanswered dmem request trips the watchdog; flag survives the response.
        step("to_req", dmem_bit, '0, '0);
        for (int i = 0; i < 10; i++) step("to_wait", '0, '0, '0);
        step("to_resp", '0, dmem_bit, '0);
        chk("to_sticky", 32'(timeout_err[DMEM_PORT]), 32'd1);
        step("to_idle", '0, '0, '0);

        // Long freeze saturates the stall counter.
        step("sat_req", imem_bit, '0, '0);
        for (int i = 0; i < 260; i++) step("sat_wait", '0, '0, '0);
        chk("sat_value", 32'(stall_cycles), 32'(SMAX));
        step("sat_resp", '0, imem_bit, '0);

        // Random traffic, mostly legal, with occasional illegal events and resets.
        do_reset("rnd_reset");
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NP; p++) begin
                rq[p] = ((($urandom % 3) == 0) && (mq[p].size() < MO)) || (($urandom % 60) == 0);
                rs[p] = ((($urandom % 3) == 0) && (mq[p].size() > 0)) || (($urandom % 80) == 0);
                fl[p] = (($urandom % 10) == 0);
            end
            step("rnd", rq, rs, fl);
            if ((n % 200) == 199) do_reset("rnd_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
